// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter.
// Carries the fetch and data ports plus busy.
interface mem_arbiter_if;
  logic        i_req;
  logic [16:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [16:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_be,
    input  d_addr, d_wdata,
    output i_rdata, i_ack,
    output d_rdata, d_ack, busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_be,
    output d_addr, d_wdata,
    input  i_rdata, i_ack,
    input  d_rdata, d_ack, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a 16-bit async SRAM.
// Each 32-bit word moves as two half-word phases.
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic [17:0]  addr,
  inout  wire  [15:0]  data,
  output logic         wre,
  output logic         oute,
  output logic         hb_mask,
  output logic         lb_mask,
  output logic         chip_en
);

  typedef enum logic [1:0] {
    IDLE, LO, HI, DONE
  } state_e;

  localparam logic [2:0] WMAX =
    3'(WAIT_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [16:0] wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] lo_q, lo_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] dr_q, dr_d;
  logic        phase_end;
  logic        phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      be_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      addr_q  <= '0;
      lo_q    <= '0;
      ir_q    <= '0;
      dr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      ir_q    <= ir_d;
      dr_q    <= dr_d;
    end
  end

  // last_q=1 means data won last, so a
  // tie after reset goes to fetch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    we_d      = we_q;
    be_d      = be_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    addr_d    = addr_q;
    lo_d      = lo_q;
    ir_d      = ir_q;
    dr_d      = dr_q;
    phase_end = (cnt_q == WMAX);
    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d = LO;
          cnt_d   = '0;
          sel_d   = bus.d_req &&
                    (!bus.i_req || !last_q);
          last_d  = sel_d;
          we_d    = sel_d ? bus.d_we : 1'b0;
          be_d    = sel_d ? bus.d_be : 4'hF;
          wa_d    = sel_d ? bus.d_addr
                          : bus.i_addr;
          wd_d    = bus.d_wdata;
          addr_d  = {wa_d, 1'b0};
        end
      end
      LO: begin
        if (phase_end) begin
          state_d = HI;
          cnt_d   = '0;
          addr_d  = {wa_q, 1'b1};
          if (!we_q) lo_d = data;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HI: begin
        if (phase_end) begin
          state_d = DONE;
          cnt_d   = '0;
          if (!we_q) begin
            if (sel_q) dr_d = {data, lo_q};
            else       ir_d = {data, lo_q};
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps an aborted
  // write from landing in the SRAM.
  always_comb begin
    phase   = (state_q == LO ||
               state_q == HI) && !reset;
    chip_en = !phase;
    oute    = !(phase && !we_q);
    wre     = !(phase && we_q);
    lb_mask = 1'b1;
    hb_mask = 1'b1;
    if (phase) begin
      if (!we_q) begin
        lb_mask = 1'b0;
        hb_mask = 1'b0;
      end else if (state_q == LO) begin
        lb_mask = ~be_q[0];
        hb_mask = ~be_q[1];
      end else begin
        lb_mask = ~be_q[2];
        hb_mask = ~be_q[3];
      end
    end
  end

  assign data = (phase && we_q)
    ? ((state_q == HI) ? wd_q[31:16]
                       : wd_q[15:0])
    : 16'hzzzz;

  assign addr        = addr_q;
  assign bus.i_rdata = ir_q;
  assign bus.d_rdata = dr_q;
  assign bus.i_ack   =
    (state_q == DONE) && !sel_q;
  assign bus.d_ack   =
    (state_q == DONE) && sel_q;
  assign bus.busy    = (state_q != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 0, extra SRAM cycles added to each half-word phase (0..7).
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request, level, held until i_ack.
REQ-005 i_addr  input  17  fetch word address.
REQ-006 i_rdata  output  32  fetched word.
REQ-007 i_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data request, level, held until d_ack.
REQ-009 d_we  input  1  1 = write, 0 = read.
REQ-010 d_be  input  4  byte enables; bit n covers d_wdata[8n+7:8n].
REQ-011 d_addr  input  17  data word address.
REQ-012 d_wdata  input  32  write word.
REQ-013 d_rdata  output  32  read word.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 busy  output  1  high whenever FSM is not IDLE.
REQ-016 addr  output  18  SRAM half-word address.
REQ-017 data  inout  16  SRAM data bus; driven only during write phases, else high-Z.
REQ-018 wre, oute, hb_mask, lb_mask, chip_en  output  1 each  SRAM write enable, output enable, high-byte mask, low-byte mask, chip enable; all active-low.

Function
REQ-019 FSM states IDLE, LO, HI, DONE; IDLE->LO on grant, LO->HI and HI->DONE after 1+WAIT_CYCLES cycles each, DONE->IDLE unconditionally.
REQ-020 Grant decided in IDLE only: single requester wins; both pending -> port not granted last wins; after reset the first tie goes to instruction port.
REQ-021 Granted port's address, we, be, wdata latched at grant; requester inputs ignored until DONE.
REQ-022 LO phase: addr = {word_addr,1'b0}, word bits [15:0]; HI phase: addr = {word_addr,1'b1}, bits [31:16] (little-endian half-words).
REQ-023 Read phase: chip_en=0, oute=0, wre=1, hb_mask=0, lb_mask=0; data sampled on last cycle of phase.
REQ-024 Write phase: chip_en=0, oute=1, wre=0, data driven with latched half; LO masks lb_mask=~be[0], hb_mask=~be[1]; HI masks lb_mask=~be[2], hb_mask=~be[3].
REQ-025 Write half with both enables clear still executes the phase with both masks high (no byte written); timing unchanged.
REQ-026 IDLE and DONE: chip_en, oute, wre, hb_mask, lb_mask all 1; data high-Z; addr holds last value.
REQ-027 Ack asserted exactly one cycle, in DONE, to the granted port only; d_ack also issued for writes.
REQ-028 Read data valid in ack cycle and held until that port's next read completes; the other port's rdata never changes.
REQ-029 Latency, grant in IDLE cycle T: ack in cycle T+3+2*WAIT_CYCLES; next grant earliest T+4+2*WAIT_CYCLES.
REQ-030 Requester drops req in the cycle after ack; req still high when IDLE is re-entered is a new request.
REQ-031 Req deasserted mid-transaction: transaction completes and ack still issued.
REQ-032 Word address wrap: i_addr/d_addr 17'h1FFFF maps to SRAM 18'h3FFFE/18'h3FFFF; no carry beyond 18 bits.

Reset
REQ-033 Reset on any edge, including mid-transaction, forces IDLE next cycle; in-flight transaction dropped without ack.
REQ-034 Reset values: i_rdata=0, d_rdata=0, i_ack=0, d_ack=0, busy=0, addr=0, data high-Z, all SRAM controls 1, arbitration history = instruction-first.

Verification
REQ-035 Bench covers: SRAM preloaded half-words 0x2004@0, 0x0000@1; i_req addr 0, WAIT_CYCLES=0 -> i_ack 3 cycles after grant, i_rdata=32'h00002004.
REQ-036 Bench covers: d_we=1, d_be=4'b1111, d_addr=5, d_wdata=32'hFFFFFFF8 -> SRAM[10]=16'hFFF8, SRAM[11]=16'hFFFF, d_ack once.
REQ-037 Bench covers: SRAM[10..11]=0; d_be=4'b0101, d_wdata=32'hAABBCCDD -> SRAM[10]=16'h00DD, SRAM[11]=16'h00BB.
REQ-038 Bench covers: i_req and d_req raised same cycle after reset, both held -> instruction granted first, data second, acks alternate, no starvation over 8 transactions.
REQ-039 Bench covers: reset asserted during HI phase of a write -> no d_ack, next cycle all controls 1, data high-Z, SRAM[odd half] unchanged.
REQ-040 Bench covers: WAIT_CYCLES=2 read -> each phase 3 cycles, ack 7 cycles after grant, busy high throughout.
